multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style main controller that sequences a shared-ALU, shared-memory multicycle MIPS datapath: one instruction takes 3–5 clock cycles instead of one. It decodes `op`/`funct` from the instruction register and drives every mux select, write enable and ALU operation in the datapath. It supports lw, sw, R-type (add/sub/and/or/slt), addi, beq, bne and j. The datapath supplies the ALU `zero` flag back to the controller for branch resolution.

## Interface
- No parameters.
- `clk` in 1 — system clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `op` in 6 — instr[31:26] from the instruction register.
- `funct` in 6 — instr[5:0] from the instruction register.
- `zero` in 1 — ALU result == 0.
- `pcen` out 1 — PC register enable.
- `irwrite` out 1 — instruction register load.
- `memwrite` out 1 — unified memory write strobe.
- `regwrite` out 1 — register file write enable.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg` out 1 — writeback select: 0 = ALUOut, 1 = Data register.
- `regdst` out 1 — destination select: 0 = rt, 1 = rd.
- `alusrca` out 1 — SrcA select: 0 = PC, 1 = register A.
- `alusrcb` out 2 — SrcB select: 00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2 — next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 3 — ALU operation.
- `state` out 4 — current state code, for debug and the bench.
- `badop` out 1 — sticky flag for an illegal op or funct.

## Operation
- States and their codes:
  - FETCH (0): iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE (1): alusrca=0, alusrcb=11, aluop=00. Next by op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQ
    - 000101 → BNE
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other op → FETCH, and badop is set.
  - MEMADR (2): alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=lw, else MEMWR.
  - MEMRD (3): iord=1. Next: MEMWB.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR (5): iord=1, memwrite=1. Next: FETCH.
  - RTYPEEX (6): alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
  - RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - BEQ (8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch condition = zero. Next: FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - ADDIWB (10): regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - JUMP (11): pcsrc=10, pcwrite=1. Next: FETCH.
  - BNE (12): same outputs as BEQ; branch condition = ~zero. Next: FETCH.
  - Codes 13–15 are unreachable; if entered, go to FETCH.
- Output rules:
  - Any output not listed for a state is 0.
  - All outputs are Moore (decoded from `state`) except `pcen`.
  - `pcen` = pcwrite | (state==BEQ & zero) | (state==BNE & ~zero).
- ALU decode:
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unknown funct → alucontrol=010 and badop is set. The instruction still completes its writeback.
- `badop` is sticky: once set it stays 1 until reset.
- Instruction length (CPI): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.

## Timing
- Reset is asynchronous: state → FETCH and badop → 0 immediately.
- While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0. Mux selects and alucontrol show the FETCH values.
- The first FETCH that takes effect is on the first rising edge after reset deasserts.
- State advances on every rising edge; there are no stall inputs.
- op/funct are sampled from the instruction register, which loads at the end of FETCH. op is therefore valid from DECODE onward.
- `zero` is used combinationally in BEQ/BNE and must be stable before the rising edge that ends that state.
- Reset asserted mid-instruction aborts it with no further strobes. A partially executed sw or lw leaves no extra writes.

## Test plan
- sw then lw: op=101011 gives states 0,1,2,5,0 with memwrite=1 only in state 5. op=100011 gives states 0,1,2,3,4,0 with regwrite=1 and memtoreg=1 only in state 4.
- R-type: op=0 with funct=101010 gives states 0,1,6,7,0; alucontrol=111 in state 6; regwrite=1 and regdst=1 in state 7; badop stays 0.
- beq/bne: beq with zero=1 gives pcen=1 and pcsrc=01 in state 8; with zero=0, pcen=0. bne with zero=0 gives pcen=1 in state 12; with zero=1, pcen=0.
- addi and j: addi gives states 0,1,9,10,0 with alusrcb=10 in state 9. j gives states 0,1,11,0 with pcen=1 and pcsrc=10 in state 11.
- Illegal encodings:
  - op=111111: DECODE goes to FETCH; badop=1 and stays 1 over the following legal instructions.
  - funct=000111: alucontrol=010 in RTYPEEX and badop=1.
- Reset mid-instruction: assert reset in MEMRD. state=0 at once, all strobes 0, badop=0. Deassert reset: FETCH runs, with irwrite=1 and pcen=1 on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller owns the master modport; the datapath side uses slave.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       badop;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state, badop
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state, badop
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for a multicycle MIPS datapath (lw/sw/R-type/addi/beq/bne/j).
// Outputs decode from the state register; only pcen also looks at the ALU zero flag.
module multicycle_ctrl (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic       badop_q, badop_d;

  logic       pcwrite, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       op_bad, funct_bad;
  logic [2:0] alu_rtype, alucontrol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      badop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      badop_q <= badop_d;
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    op_bad   = 1'b0;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          6'b100011, 6'b101011: state_d = S_MEMADR;
          6'b000000:            state_d = S_RTYPEEX;
          6'b000100:            state_d = S_BEQ;
          6'b000101:            state_d = S_BNE;
          6'b001000:            state_d = S_ADDIEX;
          6'b000010:            state_d = S_JUMP;
          default:              op_bad  = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Unknown funct still executes as add so the writeback completes predictably.
  always_comb begin
    funct_bad = 1'b0;
    case (bus.funct)
      6'b100000: alu_rtype = 3'b010;
      6'b100010: alu_rtype = 3'b110;
      6'b100100: alu_rtype = 3'b000;
      6'b100101: alu_rtype = 3'b001;
      6'b101010: alu_rtype = 3'b111;
      default: begin
        alu_rtype = 3'b010;
        funct_bad = 1'b1;
      end
    endcase
    case (aluop)
      2'b00:   alucontrol = 3'b010;
      2'b01:   alucontrol = 3'b110;
      default: alucontrol = alu_rtype;
    endcase
  end

  assign badop_d = badop_q
                 | (state_q == S_DECODE && op_bad)
                 | (state_q == S_RTYPEEX && funct_bad);

  // Strobes are held off while reset is high even though the state already reads FETCH.
  assign bus.pcen       = ~reset & (pcwrite
                                    | (state_q == S_BEQ && bus.zero)
                                    | (state_q == S_BNE && !bus.zero));
  assign bus.irwrite    = ~reset & irwrite;
  assign bus.memwrite   = ~reset & memwrite;
  assign bus.regwrite   = ~reset & regwrite;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;
  assign bus.badop      = badop_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic badop_m;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] outs_now();
    return {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.memtoreg,
            bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  function automatic logic [2:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit legal_funct(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected control word for a state, straight from the state/output table.
  function automatic logic [14:0] exp_outs(input int s, input logic [5:0] f, input logic z);
    logic pcw, irw, mw, rw, io, m2r, rd, asa;
    logic [1:0] asb, ps;
    logic [2:0] ac;
    {pcw, irw, mw, rw, io, m2r, rd, asa} = 8'b0;
    asb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (s)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; ac = rfunc(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; ps = 2'b01; ac = 3'b110; pcw = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      12: begin asa = 1; ps = 2'b01; ac = 3'b110; pcw = !z; end
      default: ;
    endcase
    return {pcw, irw, mw, rw, io, m2r, rd, asa, asb, ps, ac};
  endfunction

  localparam logic [14:0] RESET_OUTS = {8'b0, 2'b01, 2'b00, 3'b010};

  // Called at a falling edge while in FETCH; leaves at the falling edge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input int zmode);
    int   seq[$];
    logic z;
    seq = {0, 1};
    case (op)
      6'h23:   seq = {seq, 2, 3, 4};
      6'h2b:   seq = {seq, 2, 5};
      6'h00:   seq = {seq, 6, 7};
      6'h04:   seq.push_back(8);
      6'h05:   seq.push_back(12);
      6'h08:   seq = {seq, 9, 10};
      6'h02:   seq.push_back(11);
      default: ;
    endcase
    bus.op    = op;
    bus.funct = funct;
    foreach (seq[i]) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      bus.zero = z;
      #1;
      chk($sformatf("state op=%02h cyc%0d", op, i), 32'(bus.state), 32'(seq[i]));
      chk($sformatf("outs op=%02h f=%02h st%0d z=%0b", op, funct, seq[i], z),
          32'(outs_now()), 32'(exp_outs(seq[i], funct, z)));
      chk($sformatf("badop op=%02h cyc%0d", op, i), 32'(bus.badop), 32'(badop_m));
      if ((seq[i] == 1 && !legal_op(op)) || (seq[i] == 6 && !legal_funct(funct)))
        badop_m = 1'b1;
      @(negedge clk);
    end
  endtask

  logic [5:0] ops[7] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
  logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    reset    = 1'b1;
    bus.op   = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    badop_m  = 1'b0;
    @(negedge clk);
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset outs", 32'(outs_now()), 32'(RESET_OUTS));
    chk("reset badop", 32'(bus.badop), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(6'h2b, 6'b100000, 2);
    run_instr(6'h23, 6'b100000, 2);
    run_instr(6'h00, 6'b101010, 2);
    run_instr(6'h04, 6'b000000, 1);
    run_instr(6'h04, 6'b000000, 0);
    run_instr(6'h05, 6'b000000, 0);
    run_instr(6'h05, 6'b000000, 1);
    run_instr(6'h08, 6'b000000, 2);
    run_instr(6'h02, 6'b000000, 2);
    run_instr(6'h3f, 6'b100000, 2);
    run_instr(6'h00, 6'b100100, 2);
    run_instr(6'h23, 6'b100000, 2);
    run_instr(6'h00, 6'b000111, 2);

    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, 2);
    end

    // Abort an lw in MEMRD with reset.
    run_instr(6'h3e, 6'b100000, 2);
    bus.op = 6'h23;
    repeat (3) @(negedge clk);
    chk("pre-reset state", 32'(bus.state), 32'd3);
    chk("pre-reset badop", 32'(bus.badop), 32'(badop_m));
    reset = 1'b1;
    #1;
    chk("abort state", 32'(bus.state), 32'd0);
    chk("abort outs", 32'(outs_now()), 32'(RESET_OUTS));
    chk("abort badop", 32'(bus.badop), 32'd0);
    badop_m = 1'b0;
    @(negedge clk);
    chk("held state", 32'(bus.state), 32'd0);
    chk("held outs", 32'(outs_now()), 32'(RESET_OUTS));
    reset = 1'b0;
    run_instr(6'h23, 6'b100000, 2);
    run_instr(6'h2b, 6'b100000, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
